mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM states, requester ids, default abort limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    // BUSY cycles allowed before an outstanding access is abandoned.
    localparam int DEFAULT_TIMEOUT = 64;

    // A lone requester always wins; on a tie the favoured requester
    // (the one not granted last) wins.
    function automatic req_id_t pick_winner(
        input logic    cpu_pend,
        input logic    dma_pend,
        input req_id_t favoured
    );
        if (cpu_pend && dma_pend) begin
            return favoured;
        end
        if (dma_pend) begin
            return REQ_DMA;
        end
        return REQ_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) round-robin arbiter in front of a single memory controller port.
// Latency: request sampled at edge N -> mc request after N; mcRamReady sampled at edge M -> requester ready after M.
// Backpressure: requesters hold their request until their ready pulse; the memory side stalls via mcRamReady, bounded by TIMEOUT.
//
// Ports:
//   clk, reset (async, active-low)
//   cpu*/dma*  : read/write request, address, write data in; read data and one-cycle ready out
//   mc*        : read/write request, address, write data out; mcRamRead/mcRamReady in
//   grantDma   : owner of the current or most recent transaction (1 = DMA)
//   timeoutErr : one-cycle pulse when a transaction is abandoned
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpuReadReq,
    input  logic              cpuWriteReq,
    input  logic [ADDR_W-1:0] cpuAddress,
    input  logic [DATA_W-1:0] cpuWrite,
    output logic [DATA_W-1:0] cpuRead,
    output logic              cpuReady,

    input  logic              dmaReadReq,
    input  logic              dmaWriteReq,
    input  logic [ADDR_W-1:0] dmaAddress,
    input  logic [DATA_W-1:0] dmaWrite,
    output logic [DATA_W-1:0] dmaRead,
    output logic              dmaReady,

    output logic              mcReadReq,
    output logic              mcWriteReq,
    output logic [ADDR_W-1:0] mcAddress,
    output logic [DATA_W-1:0] mcWrite,
    input  logic [DATA_W-1:0] mcRamRead,
    input  logic              mcRamReady,

    output logic              grantDma,
    output logic              timeoutErr
);

    // Counter runs 0 .. TIMEOUT-1 over the BUSY cycles of one transaction.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    req_id_t           favoured_q;
    req_id_t           favoured_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              mc_read_req_d;
    logic              mc_write_req_d;
    logic [ADDR_W-1:0] mc_address_d;
    logic [DATA_W-1:0] mc_write_d;
    logic [DATA_W-1:0] cpu_read_d;
    logic [DATA_W-1:0] dma_read_d;
    logic              cpu_ready_d;
    logic              dma_ready_d;
    logic              grant_dma_d;
    logic              timeout_err_d;

    logic              cpu_pend;
    logic              dma_pend;
    req_id_t           winner;
    logic              win_write;
    logic              finish;

    assign cpu_pend  = cpuReadReq | cpuWriteReq;
    assign dma_pend  = dmaReadReq | dmaWriteReq;
    assign winner    = pick_winner(cpu_pend, dma_pend, favoured_q);
    // Read and write asserted together by one requester means write.
    assign win_write = (winner == REQ_DMA) ? dmaWriteReq : cpuWriteReq;
    // Completion by the memory takes precedence over an abort on the last allowed cycle.
    assign finish    = mcRamReady || (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d        = state_q;
        favoured_d     = favoured_q;
        cnt_d          = cnt_q;
        mc_read_req_d  = 1'b0;
        mc_write_req_d = 1'b0;
        mc_address_d   = mcAddress;
        mc_write_d     = mcWrite;
        cpu_read_d     = cpuRead;
        dma_read_d     = dmaRead;
        cpu_ready_d    = 1'b0;
        dma_ready_d    = 1'b0;
        grant_dma_d    = grantDma;
        timeout_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_pend || dma_pend) begin
                    grant_dma_d    = (winner == REQ_DMA);
                    favoured_d     = (winner == REQ_DMA) ? REQ_CPU : REQ_DMA;
                    mc_address_d   = (winner == REQ_DMA) ? dmaAddress : cpuAddress;
                    mc_write_d     = (winner == REQ_DMA) ? dmaWrite : cpuWrite;
                    mc_write_req_d = win_write;
                    mc_read_req_d  = !win_write;
                    cnt_d          = '0;
                    state_d        = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (finish) begin
                    // grantDma still names the owner; the mc request flags
                    // still carry the operation type during BUSY.
                    cpu_ready_d   = !grantDma;
                    dma_ready_d   = grantDma;
                    timeout_err_d = !mcRamReady;
                    if (mcRamReady && mcReadReq) begin
                        if (grantDma) begin
                            dma_read_d = mcRamRead;
                        end else begin
                            cpu_read_d = mcRamRead;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    mc_read_req_d  = mcReadReq;
                    mc_write_req_d = mcWriteReq;
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end

            // One dead cycle so the served requester can drop its request.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, arbitration priority and BUSY counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            favoured_q <= REQ_CPU;
            cnt_q      <= '0;
            mcReadReq  <= 1'b0;
            mcWriteReq <= 1'b0;
            mcAddress  <= '0;
            mcWrite    <= '0;
            cpuRead    <= '0;
            dmaRead    <= '0;
            cpuReady   <= 1'b0;
            dmaReady   <= 1'b0;
            grantDma   <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            favoured_q <= favoured_d;
            cnt_q      <= cnt_d;
            mcReadReq  <= mc_read_req_d;
            mcWriteReq <= mc_write_req_d;
            mcAddress  <= mc_address_d;
            mcWrite    <= mc_write_d;
            cpuRead    <= cpu_read_d;
            dmaRead    <= dma_read_d;
            cpuReady   <= cpu_ready_d;
            dmaReady   <= dma_ready_d;
            grantDma   <= grant_dma_d;
            timeoutErr <= timeout_err_d;
        end
    end

    a_one_mc_op: assert property (@(posedge clk) disable iff (!reset)
        !(mcReadReq && mcWriteReq));
    a_one_ready: assert property (@(posedge clk) disable iff (!reset)
        !(cpuReady && dmaReady));
    a_tmo_with_ready: assert property (@(posedge clk) disable iff (!reset)
        timeoutErr |-> (cpuReady || dmaReady));

endmodule
